sparc_ifu_ienc: RTL and testbench

SPARC_IFU_IENC -- requirements
Module: sparc_ifu_ienc

---
 rtl/sparc_ifu_ienc_if.sv | 30 +++
 rtl/sparc_ifu_ienc.sv | 152 +++++++++++++++
 tb/tb_sparc_ifu_ienc.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sparc_ifu_ienc_if.sv
// Request/response bundle for the SPARC immediate encoder.
// The master drives requests and consumes encoded words; the slave is the encoder.
interface sparc_ifu_ienc_if;
    logic        req_vld;
    logic        req_rdy;
    logic [2:0]  req_kind;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [5:0]  req_op3;
    logic [3:0]  req_cond;
    logic        req_annul;
    logic [31:0] req_val;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] out_inst;
    logic        out_err;
    logic [7:0]  err_cnt;

    modport master (
        output req_vld, req_kind, req_rd, req_rs1, req_op3, req_cond, req_annul, req_val,
        output out_rdy,
        input  req_rdy, out_vld, out_inst, out_err, err_cnt
    );

    modport slave (
        input  req_vld, req_kind, req_rd, req_rs1, req_op3, req_cond, req_annul, req_val,
        input  out_rdy,
        output req_rdy, out_vld, out_inst, out_err, err_cnt
    );
endinterface

// File: rtl/sparc_ifu_ienc.sv
// Two-stage SPARC instruction immediate encoder.
// S1 holds the accepted request fields; the format mux and range check sit between
// S1 and S2. S2 is the output register, so out_* come straight from flops.
// Out-of-range requests are delivered as an all-zero illtrap with out_err set.
module sparc_ifu_ienc (
    input logic             rclk,
    input logic             arst_l,
    sparc_ifu_ienc_if.slave bus
);

    logic        s1_vld_q, s1_vld_d;
    logic [2:0]  s1_kind_q, s1_kind_d;
    logic [4:0]  s1_rd_q, s1_rd_d;
    logic [4:0]  s1_rs1_q, s1_rs1_d;
    logic [5:0]  s1_op3_q, s1_op3_d;
    logic [3:0]  s1_cond_q, s1_cond_d;
    logic        s1_annul_q, s1_annul_d;
    logic [31:0] s1_val_q, s1_val_d;

    logic        s2_vld_q, s2_vld_d;
    logic [31:0] s2_inst_q, s2_inst_d;
    logic        s2_err_q, s2_err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        s2_adv;
    logic        req_acc;
    logic [31:0] enc_inst;
    logic        enc_legal;

    assign s2_adv       = ~s2_vld_q | bus.out_rdy;
    assign bus.req_rdy  = ~s1_vld_q | s2_adv;
    assign req_acc      = bus.req_vld & bus.req_rdy;
    assign bus.out_vld  = s2_vld_q;
    assign bus.out_inst = s2_inst_q;
    assign bus.out_err  = s2_err_q;
    assign bus.err_cnt  = err_cnt_q;

    // Format mux and range check on the S1 contents; ranges are tested as
    // "all bits above the field equal the sign bit".
    always_comb begin
        enc_inst  = 32'h0000_0000;
        enc_legal = 1'b0;
        case (s1_kind_q)
            3'd0: begin
                enc_inst  = {2'b10, s1_rd_q, s1_op3_q, s1_rs1_q, 1'b1, s1_val_q[12:0]};
                enc_legal = (s1_val_q[31:12] == {20{s1_val_q[31]}});
            end
            3'd1: begin
                enc_inst  = {2'b10, s1_rd_q, s1_op3_q, 1'b1, s1_cond_q, 1'b1, 2'b00, s1_val_q[10:0]};
                enc_legal = (s1_val_q[31:10] == {22{s1_val_q[31]}});
            end
            3'd2: begin
                enc_inst  = {2'b10, s1_rd_q, s1_op3_q, s1_rs1_q, 1'b1, s1_cond_q[2:0], s1_val_q[9:0]};
                enc_legal = (s1_val_q[31:9] == {23{s1_val_q[31]}});
            end
            3'd3: begin
                enc_inst  = {2'b00, s1_rd_q, 3'b100, s1_val_q[31:10]};
                enc_legal = (s1_val_q[9:0] == 10'd0);
            end
            3'd4: begin
                enc_inst  = {2'b01, s1_val_q[31:2]};
                enc_legal = (s1_val_q[1:0] == 2'd0);
            end
            3'd5: begin
                enc_inst  = {2'b00, s1_annul_q, 1'b0, s1_cond_q[2:0], 3'b011, s1_val_q[17:16],
                             1'b0, s1_rs1_q, s1_val_q[15:2]};
                enc_legal = (s1_val_q[1:0] == 2'd0) && (s1_val_q[31:17] == {15{s1_val_q[31]}});
            end
            3'd6: begin
                enc_inst  = {2'b00, s1_annul_q, s1_cond_q, 3'b010, s1_val_q[23:2]};
                enc_legal = (s1_val_q[1:0] == 2'd0) && (s1_val_q[31:23] == {9{s1_val_q[31]}});
            end
            3'd7: begin
                enc_inst  = {2'b00, s1_annul_q, s1_cond_q, 3'b001, 2'b00, 1'b1, s1_val_q[20:2]};
                enc_legal = (s1_val_q[1:0] == 2'd0) && (s1_val_q[31:20] == {12{s1_val_q[31]}});
            end
        endcase
    end

    // Next-state for both stages and the saturating error counter.
    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_kind_d  = s1_kind_q;
        s1_rd_d    = s1_rd_q;
        s1_rs1_d   = s1_rs1_q;
        s1_op3_d   = s1_op3_q;
        s1_cond_d  = s1_cond_q;
        s1_annul_d = s1_annul_q;
        s1_val_d   = s1_val_q;
        s2_vld_d   = s2_vld_q;
        s2_inst_d  = s2_inst_q;
        s2_err_d   = s2_err_q;
        err_cnt_d  = err_cnt_q;

        if (req_acc) begin
            s1_vld_d   = 1'b1;
            s1_kind_d  = bus.req_kind;
            s1_rd_d    = bus.req_rd;
            s1_rs1_d   = bus.req_rs1;
            s1_op3_d   = bus.req_op3;
            s1_cond_d  = bus.req_cond;
            s1_annul_d = bus.req_annul;
            s1_val_d   = bus.req_val;
        end else if (s2_adv) begin
            s1_vld_d = 1'b0;
        end

        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_inst_d = enc_legal ? enc_inst : 32'h0000_0000;
                s2_err_d  = ~enc_legal;
            end
        end

        if (s2_vld_q && bus.out_rdy && s2_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State registers; reset empties the pipe and clears the visible outputs.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            s1_vld_q   <= 1'b0;
            s1_kind_q  <= 3'd0;
            s1_rd_q    <= 5'd0;
            s1_rs1_q   <= 5'd0;
            s1_op3_q   <= 6'd0;
            s1_cond_q  <= 4'd0;
            s1_annul_q <= 1'b0;
            s1_val_q   <= 32'd0;
            s2_vld_q   <= 1'b0;
            s2_inst_q  <= 32'd0;
            s2_err_q   <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_kind_q  <= s1_kind_d;
            s1_rd_q    <= s1_rd_d;
            s1_rs1_q   <= s1_rs1_d;
            s1_op3_q   <= s1_op3_d;
            s1_cond_q  <= s1_cond_d;
            s1_annul_q <= s1_annul_d;
            s1_val_q   <= s1_val_d;
            s2_vld_q   <= s2_vld_d;
            s2_inst_q  <= s2_inst_d;
            s2_err_q   <= s2_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_sparc_ifu_ienc.sv
// Self-checking bench for sparc_ifu_ienc: directed vectors, backpressure,
// randomized traffic against an arithmetic reference model, error-count
// saturation and mid-flight reset.
module tb_sparc_ifu_ienc;

    logic rclk   = 1'b0;
    logic arst_l = 1'b0;
    always #5 rclk = ~rclk;

    sparc_ifu_ienc_if ifc();

    sparc_ifu_ienc dut (
        .rclk   (rclk),
        .arst_l (arst_l),
        .bus    (ifc.slave)
    );

    typedef struct {
        logic [31:0] inst;
        logic        err;
        logic [2:0]  kind;
        logic [31:0] val;
    } item_t;

    item_t       exp_q[$];
    logic [32:0] got_q[$];
    int          n_chk     = 0;
    int          n_fail    = 0;
    int          err_model = 0;
    bit          rand_rdy  = 1'b0;

    // Delivered words, in order.
    always @(posedge rclk) begin
        if (ifc.out_vld === 1'b1 && ifc.out_rdy === 1'b1)
            got_q.push_back({ifc.out_err, ifc.out_inst});
    end

    // Optional random backpressure.
    initial begin
        forever begin
            @(negedge rclk);
            if (rand_rdy) ifc.out_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    // Reference model: legality from signed integer ranges, word from shifted fields.
    function automatic item_t model(input logic [2:0] k, input logic [4:0] rd_i,
                                    input logic [4:0] rs1_i, input logic [5:0] op3_i,
                                    input logic [3:0] cond_i, input logic annul_i,
                                    input logic [31:0] val);
        item_t it;
        int    sv;
        bit    legal;
        logic [31:0] rd, rs1, op3, cond, an, w;
        sv = $signed(val);
        rd = 32'(rd_i); rs1 = 32'(rs1_i); op3 = 32'(op3_i); cond = 32'(cond_i); an = 32'(annul_i);
        w = 32'd0;
        legal = 1'b0;
        case (k)
            3'd0: begin legal = (sv >= -4096) && (sv <= 4095);
                w = (32'd2 << 30) | (rd << 25) | (op3 << 19) | (rs1 << 14) | (32'd1 << 13) | (val & 32'h1FFF); end
            3'd1: begin legal = (sv >= -1024) && (sv <= 1023);
                w = (32'd2 << 30) | (rd << 25) | (op3 << 19) | (32'd1 << 18) | (cond << 14) | (32'd1 << 13) | (val & 32'h7FF); end
            3'd2: begin legal = (sv >= -512) && (sv <= 511);
                w = (32'd2 << 30) | (rd << 25) | (op3 << 19) | (rs1 << 14) | (32'd1 << 13) | ((cond & 32'd7) << 10) | (val & 32'h3FF); end
            3'd3: begin legal = (val % 1024) == 0;
                w = (rd << 25) | (32'd4 << 22) | (val >> 10); end
            3'd4: begin legal = (val % 4) == 0;
                w = (32'd1 << 30) | (val >> 2); end
            3'd5: begin legal = ((val % 4) == 0) && (sv >= -(1 << 17)) && (sv <= (1 << 17) - 4);
                w = (an << 29) | ((cond & 32'd7) << 25) | (32'd3 << 22) | (((val >> 16) & 32'd3) << 20) | (rs1 << 14) | ((val >> 2) & 32'h3FFF); end
            3'd6: begin legal = ((val % 4) == 0) && (sv >= -(1 << 23)) && (sv <= (1 << 23) - 4);
                w = (an << 29) | (cond << 25) | (32'd2 << 22) | ((val >> 2) & 32'h3F_FFFF); end
            default: begin legal = ((val % 4) == 0) && (sv >= -(1 << 20)) && (sv <= (1 << 20) - 4);
                w = (an << 29) | (cond << 25) | (32'd1 << 22) | (32'd1 << 19) | ((val >> 2) & 32'h7_FFFF); end
        endcase
        it.inst = legal ? w : 32'd0;
        it.err  = !legal;
        it.kind = k;
        it.val  = val;
        return it;
    endfunction

    function automatic int sext(input logic [31:0] x, input int bits);
        logic [31:0] t;
        t = x << (32 - bits);
        return $signed(t) >>> (32 - bits);
    endfunction

    // Recover the immediate/offset a decoder would see.
    function automatic int decode(input logic [2:0] k, input logic [31:0] w);
        case (k)
            3'd0: return sext(w & 32'h1FFF, 13);
            3'd1: return sext(w & 32'h7FF, 11);
            3'd2: return sext(w & 32'h3FF, 10);
            3'd3: return int'((w & 32'h3F_FFFF) << 10);
            3'd4: return int'(w << 2);
            3'd5: return sext((((w >> 20) & 32'd3) << 14) | (w & 32'h3FFF), 16) * 4;
            3'd6: return sext(w & 32'h3F_FFFF, 22) * 4;
            default: return sext(w & 32'h7_FFFF, 19) * 4;
        endcase
    endfunction

    task automatic scramble();
        ifc.req_kind  = 3'($urandom);
        ifc.req_rd    = 5'($urandom);
        ifc.req_rs1   = 5'($urandom);
        ifc.req_op3   = 6'($urandom);
        ifc.req_cond  = 4'($urandom);
        ifc.req_annul = 1'($urandom);
        ifc.req_val   = $urandom;
    endtask

    // Present one request and hold it until accepted; push its expectation.
    task automatic send(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [5:0] op3, input logic [3:0] cond, input logic annul,
                        input logic [31:0] val);
        int budget = 0;
        bit done   = 1'b0;
        while (!done) begin
            @(negedge rclk);
            ifc.req_vld = 1'b1; ifc.req_kind = k; ifc.req_rd = rd; ifc.req_rs1 = rs1;
            ifc.req_op3 = op3; ifc.req_cond = cond; ifc.req_annul = annul; ifc.req_val = val;
            #1;
            if (ifc.req_rdy === 1'b1) begin
                exp_q.push_back(model(k, rd, rs1, op3, cond, annul, val));
                done = 1'b1;
            end
            @(posedge rclk);
            budget++;
            if (!done && budget > 300) begin
                n_chk++; n_fail++;
                $display("FAIL send_timeout: req_rdy=%b after %0d cycles, required 1", ifc.req_rdy, budget);
                done = 1'b1;
            end
        end
        #1;
        ifc.req_vld = 1'b0;
        scramble();
    endtask

    task automatic drain();
        int b = 0;
        while (got_q.size() < exp_q.size() && b < 1000) begin
            @(posedge rclk);
            b++;
        end
        #1;
        n_chk++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL drain_count: delivered %0d words, required %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic do_reset();
        @(negedge rclk);
        #2 arst_l = 1'b0;
        #3;
        exp_q.delete(); got_q.delete(); err_model = 0;
        @(negedge rclk);
        arst_l = 1'b1;
    endtask

    task automatic test_reset();
        ifc.req_vld = 1'b0; ifc.out_rdy = 1'b0;
        scramble();
        #12;
        n_chk++;
        if (ifc.out_vld !== 1'b0 || ifc.out_err !== 1'b0 || ifc.out_inst !== 32'd0 || ifc.err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: vld=%b err=%b inst=%h cnt=%h, required 0/0/0/0",
                     ifc.out_vld, ifc.out_err, ifc.out_inst, ifc.err_cnt);
        end
        @(negedge rclk);
        arst_l = 1'b1;
        @(posedge rclk); #1;
        n_chk++;
        if (ifc.req_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_req_rdy: req_rdy=%b, required 1", ifc.req_rdy);
        end
    endtask

    task automatic test_directed();
        logic [32:0] g;
        ifc.out_rdy = 1'b1;
        send(3'd0, 5'd3, 5'd1, 6'h00, 4'h0, 1'b0, 32'hFFFF_FFFF);
        n_chk++;
        if (ifc.out_vld !== 1'b0) begin
            n_fail++; $display("FAIL simm13_early: out_vld=%b one edge after accept, required 0", ifc.out_vld);
        end
        @(posedge rclk); #1;
        n_chk++;
        if (ifc.out_vld !== 1'b1 || ifc.out_inst !== 32'h8600_7FFF || ifc.out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL simm13_word: vld=%b inst=%h err=%b, required 1/86007fff/0",
                     ifc.out_vld, ifc.out_inst, ifc.out_err);
        end
        send(3'd6, 5'd0, 5'd0, 6'h00, 4'h8, 1'b1, 32'hFFFF_FFF8);
        send(3'd6, 5'd0, 5'd0, 6'h00, 4'h8, 1'b1, 32'h0000_0006);
        send(3'd4, 5'd0, 5'd0, 6'h00, 4'h0, 1'b0, 32'h0000_1000);
        send(3'd3, 5'd1, 5'd0, 6'h00, 4'h0, 1'b0, 32'h1234_5400);
        drain();
        if (got_q.size() == 5) begin
            void'(got_q.pop_front());
            g = got_q.pop_front(); n_chk++;
            if (g !== {1'b0, 32'h30BF_FFFE}) begin n_fail++; $display("FAIL bicc_legal: got %h, required 030bffffe", g); end
            g = got_q.pop_front(); n_chk++;
            if (g !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL bicc_misaligned: got %h, required 100000000", g); end
            g = got_q.pop_front(); n_chk++;
            if (g !== {1'b0, 32'h4000_0400}) begin n_fail++; $display("FAIL call_word: got %h, required 040000400", g); end
            g = got_q.pop_front(); n_chk++;
            if (g !== {1'b0, 32'h0304_8D15}) begin n_fail++; $display("FAIL sethi_word: got %h, required 003048d15", g); end
        end
        n_chk++;
        if (ifc.err_cnt !== 8'd1) begin
            n_fail++; $display("FAIL err_cnt_one: err_cnt=%0d, required 1", ifc.err_cnt);
        end
        err_model = 1;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_back_to_back();
        int          acc = 0;
        bit          rdy;
        logic [31:0] held;
        item_t       e;
        ifc.out_rdy = 1'b0;
        held = 32'd0;
        for (int c = 0; c < 4; c++) begin
            @(negedge rclk);
            ifc.req_vld = 1'b1; ifc.req_kind = 3'd0; ifc.req_rd = 5'(acc + 1); ifc.req_rs1 = 5'd2;
            ifc.req_op3 = 6'h02; ifc.req_cond = 4'h0; ifc.req_annul = 1'b0; ifc.req_val = 32'(acc * 100);
            #1 rdy = ifc.req_rdy;
            if (c == 2) held = ifc.out_inst;
            @(posedge rclk);
            if (rdy) begin
                exp_q.push_back(model(3'd0, 5'(acc + 1), 5'd2, 6'h02, 4'h0, 1'b0, 32'(acc * 100)));
                acc++;
            end
        end
        #1;
        n_chk++;
        if (acc != 2 || ifc.req_rdy !== 1'b0) begin
            n_fail++; $display("FAIL stall_accepts: accepted %0d req_rdy=%b, required 2/0", acc, ifc.req_rdy);
        end
        n_chk++;
        if (ifc.out_vld !== 1'b1 || ifc.out_inst !== held) begin
            n_fail++; $display("FAIL stall_hold: vld=%b inst=%h, required 1/%h", ifc.out_vld, ifc.out_inst, held);
        end
        ifc.req_vld = 1'b0;
        ifc.out_rdy = 1'b1;
        send(3'd7, 5'd0, 5'd0, 6'h00, 4'h3, 1'b0, 32'hFFF0_0000);
        send(3'd5, 5'd0, 5'd9, 6'h00, 4'h5, 1'b1, 32'h0001_FFFC);
        drain();
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (got_q[0] !== {e.err, e.inst}) begin
                n_fail++; $display("FAIL b2b_order: got %h, required %h", got_q[0], {e.err, e.inst});
            end
            void'(got_q.pop_front());
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random();
        item_t       e;
        logic [31:0] v;
        logic [2:0]  k;
        int          nerr = 0;
        logic [2:0]  bk[14] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7};
        logic [31:0] bv[14] = '{32'd4095, 32'hFFFF_F000, 32'd4096, 32'hFFFF_EFFF, 32'd1023, 32'd1024,
                                32'hFFFF_FE00, 32'hFFFF_FDFF, 32'h0001_FFFC, 32'hFFFE_0000, 32'h007F_FFFC,
                                32'h0080_0000, 32'h000F_FFFC, 32'hFFEF_FFFC};
        for (int i = 0; i < 14; i++)
            send(bk[i], 5'($urandom), 5'($urandom), 6'($urandom), 4'($urandom), 1'($urandom), bv[i]);
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            k = 3'($urandom);
            v = 32'($signed($urandom) >>> $urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) v[1:0] = 2'b00;
            if (k == 3'd3 && $urandom_range(0, 1) == 1) v[9:0] = 10'd0;
            if ($urandom_range(0, 4) == 0) @(negedge rclk);
            send(k, 5'($urandom), 5'($urandom), 6'($urandom), 4'($urandom), 1'($urandom), v);
        end
        drain();
        rand_rdy = 1'b0;
        @(negedge rclk) ifc.out_rdy = 1'b1;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (got_q[0] !== {e.err, e.inst}) begin
                n_fail++;
                $display("FAIL rand_word: kind=%0d val=%h got %h, required %h", e.kind, e.val, got_q[0], {e.err, e.inst});
            end else if (!e.err) begin
                n_chk++;
                if (decode(e.kind, got_q[0][31:0]) != int'(e.val)) begin
                    n_fail++;
                    $display("FAIL round_trip: kind=%0d decoded %h, required %h",
                             e.kind, decode(e.kind, got_q[0][31:0]), e.val);
                end
            end
            if (e.err) nerr++;
            void'(got_q.pop_front());
        end
        err_model = (err_model + nerr > 255) ? 255 : err_model + nerr;
        n_chk++;
        if (ifc.err_cnt !== 8'(err_model)) begin
            n_fail++; $display("FAIL rand_err_cnt: err_cnt=%0d, required %0d", ifc.err_cnt, err_model);
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_midflight();
        ifc.out_rdy = 1'b0;
        send(3'd2, 5'd1, 5'd1, 6'h11, 4'h1, 1'b0, 32'd512);
        send(3'd0, 5'd2, 5'd2, 6'h22, 4'h2, 1'b0, 32'd7);
        @(negedge rclk);
        #2 arst_l = 1'b0;
        #1;
        n_chk++;
        if (ifc.out_vld !== 1'b0 || ifc.err_cnt !== 8'd0 || ifc.out_inst !== 32'd0 || ifc.out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: vld=%b cnt=%0d inst=%h err=%b, required 0/0/0/0",
                     ifc.out_vld, ifc.err_cnt, ifc.out_inst, ifc.out_err);
        end
        exp_q.delete(); got_q.delete(); err_model = 0;
        @(negedge rclk);
        arst_l = 1'b1;
        ifc.out_rdy = 1'b1;
        @(posedge rclk); #1;
        n_chk++;
        if (ifc.req_rdy !== 1'b1 || ifc.out_vld !== 1'b0) begin
            n_fail++; $display("FAIL post_reset: req_rdy=%b out_vld=%b, required 1/0", ifc.req_rdy, ifc.out_vld);
        end
        for (int i = 0; i < 20; i++)
            send(3'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 4'($urandom), 1'($urandom),
                 32'($signed($urandom) >>> $urandom_range(8, 31)) & 32'hFFFF_FFFC);
        drain();
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            n_chk++;
            if (got_q[0] !== {exp_q[0].err, exp_q[0].inst}) begin
                n_fail++; $display("FAIL fresh_stream: got %h, required %h", got_q[0], {exp_q[0].err, exp_q[0].inst});
            end
            void'(got_q.pop_front());
            void'(exp_q.pop_front());
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_err_saturation();
        do_reset();
        ifc.out_rdy = 1'b1;
        for (int i = 0; i < 254; i++) send(3'd2, 5'd4, 5'd5, 6'h2F, 4'h0, 1'b0, 32'd512);
        drain();
        n_chk++;
        if (ifc.err_cnt !== 8'hFE) begin
            n_fail++; $display("FAIL err_cnt_254: err_cnt=%h, required fe", ifc.err_cnt);
        end
        for (int i = 0; i < 3; i++) send(3'd2, 5'd4, 5'd5, 6'h2F, 4'h0, 1'b0, 32'd512);
        drain();
        n_chk++;
        if (ifc.err_cnt !== 8'hFF) begin
            n_fail++; $display("FAIL err_cnt_sat: err_cnt=%h after 257 errors, required ff", ifc.err_cnt);
        end
        n_chk++;
        if (got_q.size() == 0 || got_q[got_q.size() - 1] !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL movr_illegal: last word not illtrap with err, queue size %0d", got_q.size());
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        test_err_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
